// File: rtl/modulation_reference.sv
// Sample-table modulation reference: plays back signed samples, scales by Amplitude,
// offsets to the carrier midpoint and clamps. Optional MODREF_CLAMP_FLAG_EN adds ClampHit.
module modulation_reference #(
    parameter int BIT_WIDTH = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                 MClk,
    input  logic                 Rst,
    input  logic                 WrEn,
    input  logic [ADDR_W-1:0]    WrAddr,
    input  logic [BIT_WIDTH-1:0] WrData,
    input  logic                 Enable,
    input  logic [ADDR_W:0]      SampleCount,
    input  logic [BIT_WIDTH-1:0] PeriodCount,
    input  logic [BIT_WIDTH-1:0] Amplitude,
    input  logic [BIT_WIDTH-1:0] PWMMaxCount,
    output logic [BIT_WIDTH-1:0] Compare,
    output logic                 Update,
    output logic [ADDR_W-1:0]    Index
`ifdef MODREF_CLAMP_FLAG_EN
    ,
    output logic                 ClampHit
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [BIT_WIDTH-1:0] sampleRam [DEPTH];
    logic [BIT_WIDTH-1:0] periodCnt;
    logic                 tick;
    logic [ADDR_W:0]      effCount;
    logic [ADDR_W:0]      nextIdx;

    // Pipeline: stage 1 = RAM output, stage 2 = scaled deviation, stage 3 = Compare.
    // Valid bits travel with the data; Update is the stage-3 valid, a one-cycle
    // strobe with no back-pressure, asserted in the same cycle Compare changes.
    logic                        valid1, valid2;
    logic [BIT_WIDTH-1:0]        ramData;
    logic [BIT_WIDTH-1:0]        amp1, max1, max2;
    logic signed [BIT_WIDTH+1:0] devReg;

    logic signed [2*BIT_WIDTH:0] sampleExt, ampExt, product;
    logic signed [BIT_WIDTH+1:0] deviation, midExt, maxExt, sum;
    logic [BIT_WIDTH-1:0]        clampVal;

    always_comb begin
        tick     = Enable && (periodCnt == PeriodCount);
        effCount = SampleCount;
        if (SampleCount == '0)
            effCount = (ADDR_W + 1)'(1);
        else if (SampleCount > DEPTH_L)
            effCount = DEPTH_L;
        nextIdx = {1'b0, Index} + (ADDR_W + 1)'(1);
    end

    // Read-first RAM: the non-blocking write lands after the same-edge read.
    always_ff @(posedge MClk) begin
        if (WrEn && !Rst)
            sampleRam[WrAddr] <= WrData;
        if (tick)
            ramData <= sampleRam[Index];
    end

    always_comb begin
        sampleExt = {{(BIT_WIDTH + 1){ramData[BIT_WIDTH-1]}}, ramData};
        ampExt    = {{(BIT_WIDTH + 1){1'b0}}, amp1};
        product   = sampleExt * ampExt;
        deviation = (BIT_WIDTH + 2)'(product >>> (BIT_WIDTH - 1));
        midExt    = {3'b000, max2[BIT_WIDTH-1:1]};
        maxExt    = {2'b00, max2};
        sum       = midExt + devReg;
        clampVal  = sum[BIT_WIDTH-1:0];
        if (sum < 0)
            clampVal = '0;
        else if (sum > maxExt)
            clampVal = max2;
    end

    always_ff @(posedge MClk) begin
        if (Rst) begin
            periodCnt <= '0;
            Index     <= '0;
            valid1    <= 1'b0;
            valid2    <= 1'b0;
            Update    <= 1'b0;
            Compare   <= '0;
        end else begin
            if (!Enable) begin
                periodCnt <= '0;
                Index     <= '0;
            end else if (tick) begin
                periodCnt <= '0;
                Index     <= (nextIdx >= effCount) ? '0 : nextIdx[ADDR_W-1:0];
            end else begin
                periodCnt <= periodCnt + BIT_WIDTH'(1);
            end
            valid1 <= tick;
            valid2 <= valid1;
            Update <= valid2;
            if (valid2)
                Compare <= clampVal;
        end
    end

    // Scaling operands are captured with the tick so later input changes miss in-flight samples.
    always_ff @(posedge MClk) begin
        if (tick) begin
            amp1 <= Amplitude;
            max1 <= PWMMaxCount;
        end
        if (valid1) begin
            devReg <= deviation;
            max2   <= max1;
        end
    end

`ifdef MODREF_CLAMP_FLAG_EN
    logic clampFlag;
    assign clampFlag = (sum < 0) || (sum > maxExt);

    always_ff @(posedge MClk) begin
        if (Rst)
            ClampHit <= 1'b0;
        else if (valid2)
            ClampHit <= clampFlag;
    end
`endif

endmodule
